// File: rtl/SB_codex_pkg.sv
// Shared sideband TX definitions: default packet geometry and the serializer state encoding.
`timescale 1ns/1ps
package SB_codex_pkg;

  localparam int SB_PKT_W        = 64;
  localparam int SB_GAP_UI       = 32;
  localparam int SB_PATTERN_ITER = 4;

  typedef enum logic [1:0] {
    SB_IDLE    = 2'd0,
    SB_PKT     = 2'd1,
    SB_PATTERN = 2'd2,
    SB_GAP     = 2'd3
  } sb_tx_state_e;

endpackage

// File: rtl/sb_clk_gate.sv
// Glitch-free clock gate: the enable is registered on the falling edge, so it only changes
// while the clock is low and the AND output cannot produce a runt pulse.
`timescale 1ns/1ps
module sb_clk_gate (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic gatedClk
);

  logic gateQ;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) gateQ <= 1'b0;
    else       gateQ <= enable;
  end

  assign gatedClk = clk & gateQ;

endmodule

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: 64-bit packets and SBINIT 1010.. pattern bursts onto a gated forwarded clock.
// Optional build macro SB_TX_PARITY_EN: packet MSB is replaced by even parity of the lower bits on accept.
`timescale 1ns/1ps
module sb_tx_serializer
  import SB_codex_pkg::*;
#(
  parameter int PKT_W        = SB_PKT_W,
  parameter int GAP_UI       = SB_GAP_UI,
  parameter int PATTERN_ITER = SB_PATTERN_ITER
) (
  input  logic             clk_800MHz,
  input  logic             reset,
  input  logic [PKT_W-1:0] pkt_i,
  input  logic             pkt_valid_i,
  output logic             pkt_ready_o,
  input  logic             pattern_req_i,
  output logic             pattern_done_o,
  output logic             busy_o,
  output logic             SB_clkPin_TX_o,
  output logic             SB_dataPin_TX_o,
  output logic [1:0]       dbgState
);

  // Handshake: a packet is taken at a rising edge where pkt_valid_i & pkt_ready_o; pkt_i is
  // sampled on that edge only, and the sender must hold pkt_i/pkt_valid_i stable until then.

  localparam int UI_W   = $clog2(PKT_W + GAP_UI);
  localparam int ITER_W = $clog2(PATTERN_ITER + 1);

  localparam logic [UI_W-1:0]   UI_BURST_LAST = UI_W'(PKT_W - 1);
  localparam logic [UI_W-1:0]   UI_GAP_LAST   = UI_W'(GAP_UI - 1);
  localparam logic [UI_W-1:0]   UI_GAP_TO_IDLE = UI_W'(GAP_UI - 2);
  localparam logic [ITER_W-1:0] ITER_LAST     = ITER_W'(PATTERN_ITER - 1);

  sb_tx_state_e      state;
  logic [UI_W-1:0]   uiCnt;
  logic [ITER_W-1:0] iterCnt;
  logic [PKT_W-1:0]  shReg;
  logic [PKT_W-1:0]  loadWord;
  logic              fromPattern;
  logic              runQ;
  logic              doneQ;
  logic              dataQ;
  logic              txEnable;
  logic              txBit;
  logic              accept;

`ifdef SB_TX_PARITY_EN
  assign loadWord = {^pkt_i[PKT_W-2:0], pkt_i[PKT_W-2:0]};
`else
  assign loadWord = pkt_i;
`endif

  // runQ holds ready low until the first rising edge after reset is released.
  assign pkt_ready_o    = runQ & (state == SB_IDLE) & ~pattern_req_i;
  assign accept         = pkt_valid_i & pkt_ready_o;
  assign busy_o         = (state != SB_IDLE);
  assign pattern_done_o = doneQ;
  assign dbgState       = state;

  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      state       <= SB_IDLE;
      uiCnt       <= '0;
      iterCnt     <= '0;
      shReg       <= '0;
      fromPattern <= 1'b0;
      runQ        <= 1'b0;
      doneQ       <= 1'b0;
    end else begin
      runQ  <= 1'b1;
      doneQ <= 1'b0;
      case (state)
        SB_IDLE: begin
          if (runQ && pattern_req_i) begin
            state       <= SB_PATTERN;
            uiCnt       <= '0;
            iterCnt     <= '0;
            fromPattern <= 1'b1;
          end else if (accept) begin
            state       <= SB_PKT;
            uiCnt       <= '0;
            shReg       <= loadWord;
            fromPattern <= 1'b0;
          end
        end
        SB_PKT, SB_PATTERN: begin
          shReg <= shReg >> 1;
          if (uiCnt == UI_BURST_LAST) begin
            state <= SB_GAP;
            uiCnt <= '0;
          end else begin
            uiCnt <= uiCnt + 1'b1;
          end
        end
        SB_GAP: begin
          // Returning to IDLE one cycle early lets that IDLE cycle supply the last dead UI,
          // so the next accept lands exactly PKT_W+GAP_UI after the previous one.
          if (fromPattern && (iterCnt != ITER_LAST)) begin
            if (uiCnt == UI_GAP_LAST) begin
              state   <= SB_PATTERN;
              uiCnt   <= '0;
              iterCnt <= iterCnt + 1'b1;
            end else begin
              uiCnt <= uiCnt + 1'b1;
            end
          end else if (uiCnt == UI_GAP_TO_IDLE) begin
            state <= SB_IDLE;
            uiCnt <= '0;
            if (fromPattern) begin
              doneQ   <= 1'b1;
              iterCnt <= iterCnt + 1'b1;
            end
          end else begin
            uiCnt <= uiCnt + 1'b1;
          end
        end
        default: state <= SB_IDLE;
      endcase
    end
  end

  assign txEnable = (state == SB_PKT) | (state == SB_PATTERN);

  always_comb begin
    txBit = 1'b0;
    if (state == SB_PKT)          txBit = shReg[0];
    else if (state == SB_PATTERN) txBit = ~uiCnt[0];
  end

  // Data launches on the falling edge so it is centred on the forwarded rising edge.
  always_ff @(negedge clk_800MHz or posedge reset) begin
    if (reset) dataQ <= 1'b0;
    else       dataQ <= txBit;
  end

  assign SB_dataPin_TX_o = dataQ;

  sb_clk_gate uClkGate (
    .clk      (clk_800MHz),
    .reset    (reset),
    .enable   (txEnable),
    .gatedClk (SB_clkPin_TX_o)
  );

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Bench for sb_tx_serializer: directed packets and pattern bursts, far-end frame capture,
// accept/done timing scoreboards and an in-flight reset.
`timescale 1ns/1ps
module tb_sb_tx_serializer;
  import SB_codex_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] PAT_WORD = 64'h5555_5555_5555_5555;

  localparam logic [W-1:0] V0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [W-1:0] V1 = 64'h0000_0000_0000_0001;
  localparam logic [W-1:0] V2 = 64'hFFFF_0000_A5A5_C3C3;
  localparam logic [W-1:0] V3 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] V4 = 64'hFFFF_FFFF_FFFF_FFFF;
  // Hand-computed wire images; V0 and V2 already carry even parity in bit 63.
`ifdef SB_TX_PARITY_EN
  localparam logic [W-1:0] X1 = 64'h8000_0000_0000_0001;
  localparam logic [W-1:0] X3 = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [W-1:0] X1 = 64'h0000_0000_0000_0001;
  localparam logic [W-1:0] X3 = 64'h7FFF_FFFF_FFFF_FFFF;
`endif

  logic         clk_800MHz = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pkt_i = '0;
  logic         pkt_valid_i = 1'b0;
  logic         pattern_req_i = 1'b0;
  logic         pkt_ready_o;
  logic         pattern_done_o;
  logic         busy_o;
  logic         SB_clkPin_TX_o;
  logic         SB_dataPin_TX_o;
  logic [1:0]   dbgState;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int fwdEdges = 0;
  int gapLeft = 0;
  int bitCnt = 0;
  logic gapBad = 1'b0;
  logic [W-1:0] frame = '0;

  logic [W-1:0] exp_q[$];
  int acc_q[$];
  int done_q[$];

  sb_tx_serializer dut (
    .clk_800MHz      (clk_800MHz),
    .reset           (reset),
    .pkt_i           (pkt_i),
    .pkt_valid_i     (pkt_valid_i),
    .pkt_ready_o     (pkt_ready_o),
    .pattern_req_i   (pattern_req_i),
    .pattern_done_o  (pattern_done_o),
    .busy_o          (busy_o),
    .SB_clkPin_TX_o  (SB_clkPin_TX_o),
    .SB_dataPin_TX_o (SB_dataPin_TX_o),
    .dbgState        (dbgState)
  );

  // Clock / reset: 800 MHz, posedges at 0.625 + 1.25*n.
  always #0.625 clk_800MHz = ~clk_800MHz;
  always @(posedge clk_800MHz) cyc <= cyc + 1;
  always @(posedge SB_clkPin_TX_o) fwdEdges <= fwdEdges + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int at);
    checks++;
    fails++;
    $display("FAIL %s: at cycle %0d", name, at);
  endtask

  // Far-end capture and dead-time check, sampled just after each rising edge.
  initial forever begin
    @(posedge clk_800MHz);
    #0.1;
    if (reset) begin
      bitCnt  = 0;
      gapLeft = 0;
    end else if (gapLeft > 0) begin
      if (SB_clkPin_TX_o || SB_dataPin_TX_o) gapBad = 1'b1;
      gapLeft--;
      if (gapLeft == 0) check("gap_quiet", {63'b0, gapBad}, 64'd0);
    end else if (SB_clkPin_TX_o) begin
      frame[bitCnt] = SB_dataPin_TX_o;
      bitCnt++;
      if (bitCnt == W) begin
        if (exp_q.size() == 0) flag("frame_unexpected", cyc);
        else check("frame", frame, exp_q.pop_front());
        bitCnt  = 0;
        gapLeft = 32;
        gapBad  = 1'b0;
      end
    end
  end

  // Accept and done monitors: mid-cycle sample, event belongs to the next rising edge.
  initial forever begin
    @(negedge clk_800MHz);
    #0.2;
    if (!reset && pkt_valid_i && pkt_ready_o) begin
      if (acc_q.size() == 0) flag("accept_unexpected", cyc + 1);
      else check_int("accept_cycle", cyc + 1, acc_q.pop_front());
    end
    if (!reset && pattern_done_o) begin
      if (done_q.size() == 0) flag("done_unexpected", cyc + 1);
      else check_int("done_cycle", cyc + 1, done_q.pop_front());
    end
  end

  // Drivers: called at a negedge, inputs change only on negedges.
  task automatic pulse_pattern();
    pattern_req_i = 1'b1;
    @(negedge clk_800MHz);
    pattern_req_i = 1'b0;
  endtask

  task automatic wait_accept();
    int n = 0;
    #0.2;
    while (!pkt_ready_o) begin
      if (n == 2000) begin
        flag("accept_timeout", cyc);
        return;
      end
      @(negedge clk_800MHz);
      #0.2;
      n++;
    end
    @(negedge clk_800MHz);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || gapLeft != 0 || exp_q.size() != 0 || acc_q.size() != 0 ||
            done_q.size() != 0) && n < 3000) begin
      @(negedge clk_800MHz);
      #0.2;
      n++;
    end
    if (n >= 3000) begin
      flag("idle_timeout", cyc);
      exp_q.delete();
      acc_q.delete();
      done_q.delete();
    end
    repeat (3) @(negedge clk_800MHz);
  endtask

  initial begin
    #60000;
    flag("watchdog", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    int c;
    int k;
    int e0;

    // Reset: everything low while asserted, ready only after the first edge following release.
    #50.2;
    check("rst_clk_pin", SB_clkPin_TX_o, 0);
    check("rst_data_pin", SB_dataPin_TX_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", pkt_ready_o, 0);
    check("rst_done", pattern_done_o, 0);
    check("rst_state", dbgState, SB_IDLE);
    #49.8;
    reset = 1'b0;
    #0.2;
    check("ready_before_edge", pkt_ready_o, 0);
    @(negedge clk_800MHz);
    #0.2;
    check("ready_after_edge", pkt_ready_o, 1);

    // Single packet; a pattern request while busy must be ignored.
    @(negedge clk_800MHz);
    c = cyc;
    exp_q.push_back(V0);
    acc_q.push_back(c + 1);
    pkt_i = V0;
    pkt_valid_i = 1'b1;
    wait_accept();
    pkt_valid_i = 1'b0;
    #0.2;
    check("pkt_state", dbgState, SB_PKT);
    check("pkt_busy", busy_o, 1);
    repeat (10) @(negedge clk_800MHz);
    pulse_pattern();
    wait_idle();

    // Pattern burst alone: four 1010.. frames, done 384 cycles after the request.
    @(negedge clk_800MHz);
    c = cyc;
    repeat (4) exp_q.push_back(PAT_WORD);
    done_q.push_back(c + 1 + 384);
    pulse_pattern();
    wait_idle();

    // Pattern and packet in the same cycle: pattern first, packet accepted at request+384.
    @(negedge clk_800MHz);
    c = cyc;
    repeat (4) exp_q.push_back(PAT_WORD);
    exp_q.push_back(X1);
    done_q.push_back(c + 1 + 384);
    acc_q.push_back(c + 1 + 384);
    pkt_i = V1;
    pkt_valid_i = 1'b1;
    pulse_pattern();
    wait_accept();
    pkt_valid_i = 1'b0;
    wait_idle();

    // Back-to-back packets with valid held: accepts 96 apart, 128 forwarded edges.
    @(negedge clk_800MHz);
    c = cyc;
    e0 = fwdEdges;
    exp_q.push_back(V2);
    exp_q.push_back(X3);
    acc_q.push_back(c + 1);
    acc_q.push_back(c + 1 + 96);
    pkt_i = V2;
    pkt_valid_i = 1'b1;
    wait_accept();
    pkt_i = V3;
    wait_accept();
    pkt_valid_i = 1'b0;
    wait_idle();
    check_int("fwd_edge_count", fwdEdges - e0, 128);

    // Reset in the middle of a packet: pins drop at once, no frame and no done pulse follow.
    @(negedge clk_800MHz);
    c = cyc;
    k = c + 1;
    acc_q.push_back(k);
    pkt_i = V4;
    pkt_valid_i = 1'b1;
    wait_accept();
    pkt_valid_i = 1'b0;
    while (cyc < k + 20) @(negedge clk_800MHz);
    @(posedge clk_800MHz);
    #0.3;
    check("abort_clk_before", SB_clkPin_TX_o, 1);
    reset = 1'b1;
    #0.01;
    check("abort_clk_pin", SB_clkPin_TX_o, 0);
    check("abort_data_pin", SB_dataPin_TX_o, 0);
    check("abort_busy", busy_o, 0);
    repeat (4) @(negedge clk_800MHz);
    reset = 1'b0;
    repeat (2) @(negedge clk_800MHz);
    c = cyc;
    exp_q.push_back(V0);
    acc_q.push_back(c + 1);
    pkt_i = V0;
    pkt_valid_i = 1'b1;
    wait_accept();
    pkt_valid_i = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
